// File: rtl/clmul_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : clmul_iter_unit
// Brief    : Iterative carry-less multiplier (CLMUL / CLMULH / CLMULR).
//            Retires BITS_PER_CYCLE multiplier bits per cycle and can stop
//            early once the remaining multiplier bits are all zero. Uses a
//            valid/ready issue port, holds the result under backpressure,
//            tags results with a transaction ID and supports flush.
// Revision : 1.0 - initial release
// ============================================================================
module clmul_iter_unit #(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 4,
    parameter int TRANS_ID_BITS  = 3,
    parameter int EARLY_TERM     = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [1:0]               op_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] result_trans_id_o
);

    localparam int c_STEPS = XLEN / BITS_PER_CYCLE;
    localparam int c_CNT_W = $clog2(c_STEPS) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_STEPS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_OP_CLMUL  = 2'b00;
    localparam logic [1:0] c_OP_CLMULH = 2'b01;
    localparam logic [1:0] c_OP_CLMULR = 2'b10;

    logic [1:0]               r_state;
    logic [1:0]               w_state_next;
    logic [2*XLEN-1:0]        r_acc;
    logic [2*XLEN-1:0]        r_mcand;
    logic [XLEN-1:0]          r_mplier;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [1:0]               r_op;
    logic [TRANS_ID_BITS-1:0] r_tid;
    logic [XLEN-1:0]          r_result;
    logic [TRANS_ID_BITS-1:0] r_result_tid;
    logic                     r_result_valid;

    logic [2*XLEN-1:0]        w_partial;
    logic [2*XLEN-1:0]        w_acc_next;
    logic [XLEN-1:0]          w_mplier_shift;
    logic                     w_last;
    logic [XLEN-1:0]          w_sel;

    assign ready_o           = (r_state == c_IDLE) && !flush_i;
    assign result_valid_o    = r_result_valid;
    assign result_o          = r_result;
    assign result_trans_id_o = r_result_tid;

    // Partial product of this step, final-step detection and result select.
    always_comb begin
        w_partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_mplier[j]) begin
                w_partial = w_partial ^ (r_mcand << j);
            end
        end
        w_acc_next     = r_acc ^ w_partial;
        w_mplier_shift = r_mplier >> BITS_PER_CYCLE;
        w_last         = (r_cnt == c_LAST) ||
                         ((EARLY_TERM != 0) && (w_mplier_shift == '0));
        case (r_op)
            c_OP_CLMUL:  w_sel = w_acc_next[XLEN-1:0];
            c_OP_CLMULH: w_sel = w_acc_next[2*XLEN-1:XLEN];
            c_OP_CLMULR: w_sel = w_acc_next[2*XLEN-2:XLEN-1];
            default:     w_sel = '0;
        endcase
    end

    // Next-state logic; flush overrides every state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (valid_i) w_state_next = c_BUSY;
            c_BUSY:  if (w_last) w_state_next = c_DONE;
            c_DONE:  if (result_ready_i) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
        if (flush_i) begin
            w_state_next = c_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture, iterative accumulation and registered result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc          <= '0;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_cnt          <= '0;
            r_op           <= '0;
            r_tid          <= '0;
            r_result       <= '0;
            r_result_tid   <= '0;
            r_result_valid <= 1'b0;
        end else if (flush_i) begin
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (valid_i) begin
                        r_acc    <= '0;
                        r_mcand  <= {{XLEN{1'b0}}, operand_a_i};
                        r_mplier <= operand_b_i;
                        r_cnt    <= '0;
                        r_op     <= op_i;
                        r_tid    <= trans_id_i;
                    end
                end
                c_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= w_mplier_shift;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result       <= w_sel;
                        r_result_tid   <= r_tid;
                        r_result_valid <= 1'b1;
                    end
                end
                c_DONE: begin
                    if (result_ready_i) begin
                        r_result_valid <= 1'b0;
                    end
                end
                default: begin
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/clmul_iter_unit.md
# clmul_iter_unit

Iterative carry-less multiply unit implementing the Zbc operations CLMUL, CLMULH and CLMULR for the CVA6 integer pipeline. Width, bits retired per cycle and early termination are parametrised. It sits beside the single-cycle ALU as a multi-cycle functional unit. It has a valid/ready issue handshake, a held result with backpressure, transaction-ID tagging and pipeline flush support.

## Interface
- XLEN, 64: operand/result width; 32 or 64.
- BITS_PER_CYCLE, 4: multiplier bits retired per compute cycle; power of two, divides XLEN.
- TRANS_ID_BITS, 3: width of the scoreboard transaction ID.
- EARLY_TERM, 1: 1 = stop as soon as the remaining multiplier bits are all zero.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- flush_i  in  1  kill the in-flight operation and any held result.
- valid_i  in  1  issue request.
- ready_o  out  1  unit can accept; high only in IDLE and while flush_i is low.
- op_i  in  2  00 CLMUL, 01 CLMULH, 10 CLMULR, 11 reserved (result 0).
- operand_a_i  in  XLEN  multiplicand.
- operand_b_i  in  XLEN  multiplier.
- trans_id_i  in  TRANS_ID_BITS  tag returned with the result.
- result_valid_o  out  1  result_o and result_trans_id_o valid.
- result_ready_i  in  1  consumer takes the result.
- result_o  out  XLEN  operation result.
- result_trans_id_o  out  TRANS_ID_BITS  tag of result_o.

## Operation
- Product P (2·XLEN bits) = XOR over every i with b[i]=1 of (a << i).
- CLMUL = P[XLEN-1:0]. CLMULH = P[2·XLEN-1:XLEN]. CLMULR = P[2·XLEN-2:XLEN-1]. op 11 returns all zeros with normal latency.
- Registers:
  - 2·XLEN accumulator.
  - Shifted multiplicand (a << processed bit count).
  - Remaining multiplier (b >> processed bit count).
  - Step counter, log2(XLEN/BITS_PER_CYCLE)+1 bits.
  - Latched op and trans_id.
- FSM:
  - IDLE: ready_o=1. When valid_i & ready_o, latch operands, op and trans_id, clear the accumulator and go to BUSY.
  - BUSY: each cycle XOR in a<<j for each set bit j of the low BITS_PER_CYCLE bits of the remaining multiplier, then advance the shift registers by BITS_PER_CYCLE and increment the counter. Go to DONE when the counter reaches XLEN/BITS_PER_CYCLE, or (EARLY_TERM=1) when the post-shift remaining multiplier is zero.
  - DONE: result_valid_o=1. Outputs are selected from the accumulator by op and held stable until result_ready_i=1, then go to IDLE.
- Flush: flush_i=1 in any state → IDLE at the next edge, result discarded, result_valid_o low the next cycle. valid_i is ignored while flush_i=1.
- No new issue is accepted in DONE, even in the cycle result_ready_i is high; ready_o rises one cycle later.

## Timing
- Reset values: FSM=IDLE, ready_o=1, result_valid_o=0, result_o=0, result_trans_id_o=0, accumulator and counter 0.
- Reset asserted mid-operation aborts immediately; no result is produced.
- Latency is measured from the accept edge to result_valid_o high.
  - EARLY_TERM=0: XLEN/BITS_PER_CYCLE cycles (16 at default).
  - EARLY_TERM=1: max(1, ceil((msb_index(b)+1)/BITS_PER_CYCLE)) cycles. b=0 gives 1.
- Throughput: one op per latency+2 cycles minimum (DONE cycle plus return to IDLE).
- result_o, result_trans_id_o and result_valid_o are registered; no combinational path from any input to them.
- ready_o depends combinationally only on the FSM state and flush_i.

## Test plan
- Basic: CLMUL a=0x3, b=0x3, trans_id=5 → result_o=0x5, result_trans_id_o=5, result_valid_o high exactly 1 cycle after accept (EARLY_TERM=1).
- High/reverse: a=b=0x8000_0000_0000_0000.
  - CLMULH → 0x4000_0000_0000_0000; CLMULR → 0x8000_0000_0000_0000; CLMUL → 0.
  - Each has latency 16.
- Latency sweep: b=0x0 → 1 cycle, result 0; b=0x10 → 2 cycles; b=0xFFFF_FFFF_FFFF_FFFF, a=0x1, CLMUL → 0xFFFF_FFFF_FFFF_FFFF in 16 cycles. Repeat with EARLY_TERM=0: all 16 cycles.
- Backpressure: hold result_ready_i=0 for 10 cycles after result_valid_o.
  - Result stays stable and ready_o stays 0 throughout.
  - After the handshake, ready_o=1 the next cycle.
- Flush: assert flush_i 3 cycles into BUSY, with valid_i=1 in the same cycle.
  - No accept occurs; IDLE next cycle; no result_valid_o pulse.
  - A following op completes correctly.
- Reset: assert rst_ni=0 asynchronously mid-BUSY.
  - Outputs reach their reset values without a clock edge.
  - After release, CLMUL a=0x5, b=0x7 → 0x1B.
